// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if: start/done handshake, branch inputs, datapath strobes and debug counters
interface branch_sequencer_if #(parameter int CNT_W = 16);
    logic             start;
    logic [4:0]       ir_op;
    logic             con_ff;
    logic             mem_ready;
    logic             busy, done, illegal;
    logic             pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in;
    logic             read, mdata_in, mdr_in, mdr_out, ir_in, gra, r_out, con_in, y_in, c_out, alu_add;
    logic [CNT_W-1:0] taken_cnt, not_taken_cnt;
    modport master(
        output start, ir_op, con_ff, mem_ready,
        input  busy, done, illegal,
        input  pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in,
        input  read, mdata_in, mdr_in, mdr_out, ir_in, gra, r_out, con_in, y_in, c_out, alu_add,
        input  taken_cnt, not_taken_cnt
    );
    modport slave(
        input  start, ir_op, con_ff, mem_ready,
        output busy, done, illegal,
        output pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in,
        output read, mdata_in, mdr_in, mdr_out, ir_in, gra, r_out, con_in, y_in, c_out, alu_add,
        output taken_cnt, not_taken_cnt
    );
endinterface

// File: rtl/branch_sequencer.sv
// branch_sequencer: sequences conditional branches through T0..T6 with saturating taken/not-taken counters.
// Define MEM_WAIT_EN to hold T1 until mem_ready; otherwise mem_ready is ignored.
module branch_sequencer #(
    parameter logic [4:0] BR_OPCODE = 5'b10010,
    parameter int          CNT_W     = 16
) (
    input logic              clk,
    input logic              clear,
    branch_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] taken_q, not_taken_q;
    logic             is_br;
    assign is_br = bus.ir_op == BR_OPCODE;
    always_ff @(posedge clk) begin
        if (!clear) begin
            state       <= IDLE;
            taken_q     <= '0;
            not_taken_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == T6 && bus.con_ff && taken_q != '1)
                taken_q <= taken_q + 1'b1;
            if (state == T6 && !bus.con_ff && not_taken_q != '1)
                not_taken_q <= not_taken_q + 1'b1;
        end
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.start ? T0 : IDLE;
            T0:      state_nxt = T1;
`ifdef MEM_WAIT_EN
            T1:      state_nxt = bus.mem_ready ? T2 : T1;
`else
            T1:      state_nxt = T2;
`endif
            T2:      state_nxt = T3;
            T3:      state_nxt = is_br ? T4 : IDLE;
            T4:      state_nxt = T5;
            T5:      state_nxt = T6;
            default: state_nxt = IDLE;
        endcase
    end
    // Moore decode; only pc_in in T6 and the T3 opcode check look at inputs
    assign bus.busy     = state != IDLE;
    assign bus.done     = state == T6;
    assign bus.illegal  = state == T3 && !is_br;
    assign bus.pc_out   = state == T0 || state == T4;
    assign bus.mar_in   = state == T0;
    assign bus.inc_pc   = state == T0;
    assign bus.z_in     = state == T0 || state == T5;
    assign bus.zlow_out = state == T1 || state == T6;
    assign bus.pc_in    = state == T1 || (state == T6 && bus.con_ff);
    assign bus.read     = state == T1;
    assign bus.mdata_in = state == T1;
    assign bus.mdr_in   = state == T1;
    assign bus.mdr_out  = state == T2;
    assign bus.ir_in    = state == T2;
    assign bus.gra      = state == T3;
    assign bus.r_out    = state == T3;
    assign bus.con_in   = state == T3 && is_br;
    assign bus.y_in     = state == T4;
    assign bus.c_out    = state == T5;
    assign bus.alu_add  = state == T5;
    assign bus.taken_cnt     = taken_q;
    assign bus.not_taken_cnt = not_taken_q;
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: scoreboard bench for branch_sequencer (CNT_W=2 so saturation is reachable).
module tb_branch_sequencer;
    localparam int         CW    = 2;
    localparam logic [4:0] BR_OP = 5'b10010;
    typedef struct {
        logic          ill;
        int            at;
        logic [CW-1:0] tk;
        logic [CW-1:0] nt;
    } exp_t;
    logic          clk = 0;
    logic          clear = 0;
    int            checks = 0;
    int            failures = 0;
    int            cycle = 0;
    logic [CW-1:0] m_tk = '0, m_nt = '0;
    exp_t          sbq[$];
    exp_t          got;
    logic          have_got;
    branch_sequencer_if #(.CNT_W(CW)) bus();
    branch_sequencer #(.BR_OPCODE(BR_OP), .CNT_W(CW)) dut(.clk(clk), .clear(clear), .bus(bus.slave));
    always #5 clk = ~clk;
    wire [16:0] strobes = {bus.pc_out, bus.mar_in, bus.inc_pc, bus.z_in, bus.zlow_out, bus.pc_in,
                           bus.read, bus.mdata_in, bus.mdr_in, bus.mdr_out, bus.ir_in, bus.gra,
                           bus.r_out, bus.con_in, bus.y_in, bus.c_out, bus.alu_add};
    wire [2:0] drivers = {2'b0, bus.pc_out} + {2'b0, bus.zlow_out} + {2'b0, bus.mdr_out} + {2'b0, bus.r_out} + {2'b0, bus.c_out};
    task automatic cyc();
        @(posedge clk);
        #1;
        cycle++;
    endtask
    function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction
    function automatic logic [16:0] exp_strobe(input int st, input logic con, input logic legal);
        case (st)
            0:       return 17'b11110000000000000;
            1:       return 17'b00001111100000000;
            2:       return 17'b00000000011000000;
            3:       return legal ? 17'b00000000000111000 : 17'b00000000000110000;
            4:       return 17'b10000000000000100;
            5:       return 17'b00010000000000011;
            6:       return con ? 17'b00001100000000000 : 17'b00001000000000000;
            default: return 17'b0;
        endcase
    endfunction
    task automatic pop_completion();
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL completion: unexpected done/illegal at cycle %0d, required none", cycle);
        end else begin
            got = sbq.pop_front();
            have_got = 1;
            checks++;
            if (bus.illegal !== got.ill || cycle != got.at) begin
                failures++;
                $display("FAIL completion: illegal=%b cycle=%0d, required illegal=%b cycle=%0d", bus.illegal, cycle, got.ill, got.at);
            end
        end
    endtask
    task automatic check_idle(input string name, input logic [CW-1:0] tk, input logic [CW-1:0] nt);
        checks++;
        if (bus.busy !== 0 || bus.done !== 0 || bus.illegal !== 0 || strobes !== 0 ||
            bus.taken_cnt !== tk || bus.not_taken_cnt !== nt) begin
            failures++;
            $display("FAIL %s: busy=%b done=%b illegal=%b strobes=%b tk=%0d nt=%0d, required idle zeros tk=%0d nt=%0d",
                     name, bus.busy, bus.done, bus.illegal, strobes, bus.taken_cnt, bus.not_taken_cnt, tk, nt);
        end
    endtask
    task automatic run_instr(input string name, input logic [4:0] op, input logic con, input int waits);
        exp_t e;
        int   steps[$];
        int   t1 = 0;
        int   st;
        int   t1_n;
        logic legal;
        legal = op == BR_OP;
`ifdef MEM_WAIT_EN
        t1_n = waits + 1;
`else
        t1_n = 1;
`endif
        steps.push_back(0);
        repeat (t1_n) steps.push_back(1);
        steps.push_back(2);
        steps.push_back(3);
        if (legal) begin
            steps.push_back(4);
            steps.push_back(5);
            steps.push_back(6);
            if (con) m_tk = sat(m_tk);
            else m_nt = sat(m_nt);
        end
        e.ill = !legal;
        e.at  = cycle + steps.size();
        e.tk  = m_tk;
        e.nt  = m_nt;
        sbq.push_back(e);
        have_got = 0;
        bus.start = 1; bus.ir_op = op; bus.con_ff = ~con; bus.mem_ready = 0;
        foreach (steps[i]) begin
            cyc();
            bus.start = 0;
            st = steps[i];
            if (st == 1) t1++;
            bus.mem_ready = t1 > waits;
            bus.con_ff = (st == 6) ? con : ~con;
            #1;
            checks++;
            if (strobes !== exp_strobe(st, con, legal) || bus.busy !== 1 || drivers > 1 ||
                bus.done !== (st == 6) || bus.illegal !== (st == 3 && !legal)) begin
                failures++;
                $display("FAIL %s step%0d: strobes=%b busy=%b done=%b illegal=%b, required strobes=%b busy=1 done=%b illegal=%b",
                         name, st, strobes, bus.busy, bus.done, bus.illegal, exp_strobe(st, con, legal), st == 6, st == 3 && !legal);
            end
            if (bus.done === 1 || bus.illegal === 1) pop_completion();
        end
        cyc();
        checks++;
        if (!have_got) begin
            failures++;
            $display("FAIL %s: no completion seen, required one by cycle %0d", name, e.at);
        end else check_idle(name, got.tk, got.nt);
    endtask
    task automatic test_reset();
        clear = 0; bus.start = 0; bus.ir_op = 0; bus.con_ff = 0; bus.mem_ready = 0;
        cyc(); cyc();
        clear = 1;
        repeat (5) begin
            cyc();
            check_idle("reset", '0, '0);
        end
    endtask
    task automatic test_taken();     run_instr("taken", BR_OP, 1, 0);        endtask
    task automatic test_not_taken(); run_instr("not_taken", BR_OP, 0, 0);    endtask
    task automatic test_illegal();   run_instr("illegal", 5'b00011, 1, 0);   endtask
    task automatic test_mem_wait();  run_instr("mem_wait", BR_OP, 1, 3);     endtask
    task automatic test_mid_reset();
        bus.start = 1; bus.ir_op = BR_OP; bus.con_ff = 1;
        repeat (5) begin
            cyc();
            bus.start = 0;
        end
        checks++;
        if (strobes !== exp_strobe(4, 1, 1)) begin
            failures++;
            $display("FAIL mid_reset T4: strobes=%b, required %b", strobes, exp_strobe(4, 1, 1));
        end
        clear = 0;
        cyc();
        m_tk = '0; m_nt = '0;
        check_idle("mid_reset", '0, '0);
        clear = 1;
        run_instr("after_reset", BR_OP, 1, 0);
    endtask
    task automatic test_back_to_back();
        exp_t e;
        int   c0;
        c0 = cycle;
        have_got = 0;
        for (int k = 0; k < 2; k++) begin
            m_tk = sat(m_tk);
            e.ill = 0; e.at = c0 + 7 + 8 * k; e.tk = m_tk; e.nt = m_nt;
            sbq.push_back(e);
        end
        bus.start = 1; bus.ir_op = BR_OP; bus.con_ff = 1;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (k >= 15) bus.start = 0;
            #1;
            checks++;
            if (bus.busy !== !(k == 8 || k == 16) || bus.done !== (k == 7 || k == 15)) begin
                failures++;
                $display("FAIL back_to_back k=%0d: busy=%b done=%b, required busy=%b done=%b",
                         k, bus.busy, bus.done, !(k == 8 || k == 16), k == 7 || k == 15);
            end
            if (bus.done === 1) pop_completion();
        end
        check_idle("back_to_back", m_tk, m_nt);
    endtask
    task automatic test_saturation();
        run_instr("sat_taken", BR_OP, 1, 0);
        for (int i = 0; i < 4; i++) run_instr("sat_not_taken", BR_OP, 0, 0);
    endtask
    initial begin
        test_reset();
        test_taken();
        test_not_taken();
        test_illegal();
        test_mid_reset();
        test_mem_wait();
        test_back_to_back();
        test_saturation();
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard: %0d pending, required 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
